// File: rtl/fhe_op_sequencer_pkg.sv
// Shared types for the FHE op sequencer: op payload, mode encoding, FSM states.
package fhe_op_sequencer_pkg;

  typedef enum logic [2:0] {
    NO_OP        = 3'd0,
    OP_CT_CT_ADD = 3'd1,
    OP_CT_PT_ADD = 3'd2,
    OP_CT_PT_MUL = 3'd3,
    OP_CT_CT_MUL = 3'd4
  } mode_t;

  typedef struct packed {
    mode_t      mode;
    logic [3:0] idx0;
    logic [3:0] idx1;
    logic [3:0] idx2;
    logic [3:0] idx3;
    logic [3:0] out0;
    logic [3:0] out1;
  } operation;

  localparam int unsigned OP_W            = $bits(operation);
  localparam int unsigned DEF_DEPTH       = 4;
  localparam int unsigned DEF_ADD_TIMEOUT = 64;
  localparam int unsigned DEF_MUL_TIMEOUT = 500;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    SETTLE = 2'd3
  } seq_state_t;

  function automatic logic is_mul_mode(input mode_t m);
    return (m == OP_CT_PT_MUL) || (m == OP_CT_CT_MUL);
  endfunction

endpackage

// File: rtl/fhe_op_sequencer_if.sv
// Host request channel and cpu issue channel of the sequencer.
interface fhe_op_sequencer_if;
  import fhe_op_sequencer_pkg::*;

  logic     req_valid;
  logic     req_ready;
  operation req_op;
  operation cpu_op;
  logic     cpu_done;

  // master: host + cpu environment; slave: the sequencer
  modport master (output req_valid, output req_op, output cpu_done,
                  input  req_ready, input  cpu_op);
  modport slave  (input  req_valid, input  req_op, input  cpu_done,
                  output req_ready, output cpu_op);
endinterface

// File: rtl/fhe_op_sequencer_op_fifo.sv
// Synchronous op FIFO with occupancy count; push is dropped when full.
module fhe_op_sequencer_op_fifo
  import fhe_op_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  operation                 wr_data,
  input  logic                     pop,
  output operation                 rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  operation        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // storage carries no reset; only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fhe_op_sequencer.sv
// Issues buffered FHE ops to the cpu one at a time: pulse, wait for done/timeout, settle.
module fhe_op_sequencer
  import fhe_op_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned ADD_TIMEOUT = DEF_ADD_TIMEOUT,
  parameter int unsigned MUL_TIMEOUT = DEF_MUL_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  fhe_op_sequencer_if.slave        bus,
  input  logic                     err_clear,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              ops_done
);

  localparam int unsigned CNT_W = $clog2(MUL_TIMEOUT + 1);

  seq_state_t       state;
  seq_state_t       next_state;
  operation         head;
  operation         cur_op;
  operation         hold_op;
  logic             full;
  logic             empty;
  logic             pop;
  logic             issue_start;
  logic             done_hit;
  logic             timeout_hit;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit_m1;

  fhe_op_sequencer_op_fifo #(.DEPTH(DEPTH)) u_op_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (bus.req_valid),
    .wr_data (bus.req_op),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  assign bus.req_ready = !full;
  assign busy          = (state != IDLE) || (fifo_count != '0);
  assign limit_m1      = is_mul_mode(cur_op.mode) ? CNT_W'(MUL_TIMEOUT - 1)
                                                  : CNT_W'(ADD_TIMEOUT - 1);

  // cpu sees the operands of the current op with mode forced to NO_OP outside ISSUE
  always_comb begin
    hold_op      = cur_op;
    hold_op.mode = NO_OP;
  end

  // next-state and control strobes
  always_comb begin
    next_state  = state;
    pop         = 1'b0;
    issue_start = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.mode != NO_OP) begin
            issue_start = 1'b1;
            next_state  = ISSUE;
          end
        end
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (bus.cpu_done) begin
          done_hit   = 1'b1;
          next_state = SETTLE;
        end else if (cnt == limit_m1) begin
          timeout_hit = 1'b1;
          next_state  = SETTLE;
        end
      end
      SETTLE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // op latch, registered cpu output, wait counter, status
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_op      <= '0;
      bus.cpu_op  <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
      ops_done    <= '0;
    end else begin
      if (issue_start) begin
        cur_op     <= head;
        bus.cpu_op <= head;
      end else begin
        bus.cpu_op <= hold_op;
      end

      if (state == ISSUE) begin
        cnt <= '0;
      end else if (state == WAIT && !bus.cpu_done && cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end else if (err_clear) begin
        timeout_err <= 1'b0;
      end

      if (done_hit) ops_done <= ops_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_fhe_op_sequencer.sv
// Directed self-checking bench for fhe_op_sequencer (DEPTH=4, ADD=64, MUL=500).
module tb_fhe_op_sequencer;
  import fhe_op_sequencer_pkg::*;

  logic        clk;
  logic        reset;
  logic        err_clear;
  logic        busy;
  logic        timeout_err;
  logic [2:0]  fifo_count;
  logic [15:0] ops_done;

  int          n_checks;
  int          n_fail;
  int          cyc;
  int          rep_viol;
  logic        prev_issue;
  operation    issued_q[$];
  operation    ops[6];
  operation    op_a;
  operation    op_b;
  int          push_cyc;
  int          n;

  fhe_op_sequencer_if bus ();

  fhe_op_sequencer #(.DEPTH(4), .ADD_TIMEOUT(64), .MUL_TIMEOUT(500)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .err_clear   (err_clear),
    .busy        (busy),
    .timeout_err (timeout_err),
    .fifo_count  (fifo_count),
    .ops_done    (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // records every non-NO_OP cycle seen on cpu_op and flags back-to-back issues
  always @(negedge clk) begin
    if (bus.cpu_op.mode != NO_OP) begin
      issued_q.push_back(bus.cpu_op);
      if (prev_issue) rep_viol++;
      prev_issue = 1'b1;
    end else begin
      prev_issue = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic operation mk_op(input mode_t m, input int unsigned a, input int unsigned b,
                                     input int unsigned c, input int unsigned d,
                                     input int unsigned o0, input int unsigned o1);
    operation o;
    o.mode = m;
    o.idx0 = 4'(a);
    o.idx1 = 4'(b);
    o.idx2 = 4'(c);
    o.idx3 = 4'(d);
    o.out0 = 4'(o0);
    o.out1 = 4'(o1);
    return o;
  endfunction

  task automatic push_op(input operation op);
    bus.req_op    = op;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    int k;
    k = 0;
    while (bus.cpu_op.mode == NO_OP && k < 10) begin
      tick();
      k++;
    end
    check(tag, 64'(bus.cpu_op.mode != NO_OP), 64'(1));
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    cyc           = 0;
    rep_viol      = 0;
    prev_issue    = 1'b0;
    reset         = 1'b1;
    err_clear     = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.cpu_done  = 1'b0;
    tick(); tick(); tick();
    check("rst_count",  64'(fifo_count),  64'(0));
    check("rst_cpu_op", 64'(bus.cpu_op),  64'(0));
    check("rst_err",    64'(timeout_err), 64'(0));
    check("rst_done",   64'(ops_done),    64'(0));
    check("rst_busy",   64'(busy),        64'(0));
    reset = 1'b0;
    tick();
    check("rst_ready",  64'(bus.req_ready), 64'(1));

    // single ADD with done three cycles after issue
    op_a = mk_op(OP_CT_CT_ADD, 0, 1, 2, 3, 5, 6);
    push_cyc = cyc + 1;
    push_op(op_a);
    wait_issue("t1_issue");
    check("t1_issue_op", 64'(bus.cpu_op), 64'(op_a));
    tick();
    check("t1_wait_mode", 64'(bus.cpu_op.mode), 64'(NO_OP));
    check("t1_wait_out0", 64'(bus.cpu_op.out0), 64'(5));
    tick();
    bus.cpu_done = 1'b1;
    tick();
    bus.cpu_done = 1'b0;
    check("t1_ops_done", 64'(ops_done), 64'(1));
    while (busy && (cyc - push_cyc) < 7) tick();
    check("t1_busy_low", 64'(busy), 64'(0));
    check("t1_issue_cnt", 64'(issued_q.size()), 64'(1));

    // five back-to-back pushes with done held low, sixth rejected
    issued_q.delete();
    for (int i = 0; i < 6; i++)
      ops[i] = mk_op((i % 2 == 0) ? OP_CT_CT_ADD : OP_CT_PT_ADD, i, i + 1, i + 2, i + 3, 8 + i, i);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.req_op = ops[i];
      tick();
    end
    check("t2_full_count", 64'(fifo_count),    64'(4));
    check("t2_not_ready",  64'(bus.req_ready), 64'(0));
    bus.req_op = ops[5];
    tick();
    bus.req_valid = 1'b0;
    check("t2_ignored",    64'(fifo_count),    64'(4));
    check("t2_first_only", 64'(issued_q.size()), 64'(1));
    bus.cpu_done = 1'b1;
    n = 0;
    while ((issued_q.size() < 5 || busy) && n < 60) begin
      tick();
      n++;
    end
    bus.cpu_done = 1'b0;
    tick();
    check("t2_issue_cnt", 64'(issued_q.size()), 64'(5));
    for (int i = 0; i < 5; i++)
      if (i < issued_q.size()) check($sformatf("t2_order%0d", i), 64'(issued_q[i]), 64'(ops[i]));
    check("t2_ops_done", 64'(ops_done), 64'(6));

    // MUL timeout after 500 WAIT cycles; queued ADD issues two cycles later
    issued_q.delete();
    op_a = mk_op(OP_CT_CT_MUL, 1, 2, 3, 4, 7, 9);
    op_b = mk_op(OP_CT_PT_ADD, 9, 8, 7, 6, 3, 2);
    push_op(op_a);
    push_op(op_b);
    wait_issue("t3_issue");
    check("t3_mul_op", 64'(bus.cpu_op), 64'(op_a));
    for (int i = 0; i < 500; i++) tick();
    check("t3_err_early", 64'(timeout_err), 64'(0));
    tick();
    check("t3_err_set",   64'(timeout_err), 64'(1));
    check("t3_no_count",  64'(ops_done),    64'(6));
    tick();
    check("t3_gap_noop",  64'(bus.cpu_op.mode), 64'(NO_OP));
    tick();
    check("t3_next_op",   64'(bus.cpu_op), 64'(op_b));
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("t3_err_clear", 64'(timeout_err), 64'(0));
    bus.cpu_done = 1'b1;
    tick();
    bus.cpu_done = 1'b0;
    tick();
    check("t3_ops_done",  64'(ops_done), 64'(7));

    // NO_OP entry is discarded, only the ADD reaches the cpu
    issued_q.delete();
    op_a = mk_op(NO_OP, 1, 1, 1, 1, 1, 1);
    op_b = mk_op(OP_CT_PT_ADD, 4, 3, 2, 1, 0, 15);
    bus.cpu_done = 1'b1;
    push_op(op_a);
    push_op(op_b);
    for (int i = 0; i < 15; i++) tick();
    bus.cpu_done = 1'b0;
    check("t4_issue_cnt", 64'(issued_q.size()), 64'(1));
    if (issued_q.size() > 0) check("t4_issue_op", 64'(issued_q[0]), 64'(op_b));
    check("t4_ops_done",  64'(ops_done), 64'(8));

    // done during ISSUE is stale; done in first WAIT cycle counts once
    op_a = mk_op(OP_CT_CT_ADD, 2, 2, 2, 2, 4, 4);
    push_op(op_a);
    wait_issue("t6_issue");
    bus.cpu_done = 1'b1;
    tick();
    check("t6_issue_done_ignored", 64'(ops_done), 64'(8));
    tick();
    bus.cpu_done = 1'b0;
    check("t6_wait_done", 64'(ops_done), 64'(9));
    tick(); tick();
    check("t6_once", 64'(ops_done), 64'(9));

    // done on the last WAIT cycle beats the timeout
    push_op(mk_op(OP_CT_PT_ADD, 3, 3, 3, 3, 6, 6));
    wait_issue("t6b_issue");
    for (int i = 0; i < 64; i++) tick();
    check("t6b_still_wait", 64'(busy), 64'(1));
    check("t6b_no_err_yet", 64'(timeout_err), 64'(0));
    bus.cpu_done = 1'b1;
    tick();
    bus.cpu_done = 1'b0;
    check("t6b_no_err",  64'(timeout_err), 64'(0));
    check("t6b_counted", 64'(ops_done), 64'(10));

    // timeout set wins over a concurrent err_clear
    tick(); tick();
    push_op(mk_op(OP_CT_CT_ADD, 5, 5, 5, 5, 1, 1));
    wait_issue("t6c_issue");
    err_clear = 1'b1;
    for (int i = 0; i < 64; i++) tick();
    check("t6c_err_early", 64'(timeout_err), 64'(0));
    tick();
    check("t6c_set_wins",  64'(timeout_err), 64'(1));
    tick();
    check("t6c_cleared",   64'(timeout_err), 64'(0));
    err_clear = 1'b0;
    check("t6c_no_count",  64'(ops_done), 64'(10));
    tick(); tick();

    // reset during WAIT with two ops queued
    push_op(mk_op(OP_CT_CT_ADD, 6, 6, 6, 6, 2, 2));
    wait_issue("t5_issue");
    push_op(mk_op(OP_CT_PT_ADD, 7, 7, 7, 7, 3, 3));
    push_op(mk_op(OP_CT_CT_MUL, 8, 8, 8, 8, 4, 4));
    check("t5_queued", 64'(fifo_count), 64'(2));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_count",  64'(fifo_count),  64'(0));
    check("t5_cpu_op", 64'(bus.cpu_op),  64'(0));
    check("t5_busy",   64'(busy),        64'(0));
    check("t5_done",   64'(ops_done),    64'(0));
    issued_q.delete();
    for (int i = 0; i < 6; i++) tick();
    check("t5_no_issue", 64'(issued_q.size()), 64'(0));
    check("t5_ready",    64'(bus.req_ready),   64'(1));
    check("no_repeat",   64'(rep_viol),        64'(0));

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
